// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: line-code constants and the transmit framer state set.
package eth_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_IFG
    } eth_tx_state_e;

endpackage

// File: rtl/preamble_sfd_inserter.sv
// Prepends an Ethernet preamble + SFD to each AXI-Stream payload frame and
// enforces a minimum inter-frame gap before the next frame may start.
module preamble_sfd_inserter
    import eth_pkg::*;
#(
    parameter int DATA_BYTES   = 1,
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_BYTES    = 12
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [15:0]             frame_count
);

    localparam int NB         = PREAMBLE_LEN / DATA_BYTES;
    localparam int IFG_CYCLES = (IFG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int BEAT_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam int IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);
    localparam logic [IFG_W-1:0]  LAST_IFG  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    // Reject illegal configurations when the design is elaborated.
    if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4 || DATA_BYTES == 8)) begin : g_bad_data_bytes
        $error("preamble_sfd_inserter: DATA_BYTES must be 1, 2, 4 or 8");
    end
    if (PREAMBLE_LEN < DATA_BYTES || (PREAMBLE_LEN % DATA_BYTES) != 0) begin : g_bad_preamble_len
        $error("preamble_sfd_inserter: PREAMBLE_LEN must be a non-zero multiple of DATA_BYTES");
    end
    if (IFG_BYTES < 0) begin : g_bad_ifg
        $error("preamble_sfd_inserter: IFG_BYTES must not be negative");
    end

    // Every lane is 0x55, except the last lane of the final preamble beat carries the SFD.
    function automatic logic [8*DATA_BYTES-1:0] preamble_beat(input logic [BEAT_W-1:0] beat);
        logic [8*DATA_BYTES-1:0] d;
        for (int lane = 0; lane < DATA_BYTES; lane++) begin
            d[8*lane +: 8] = (beat == LAST_BEAT && lane == DATA_BYTES - 1) ? SFD_BYTE : PREAMBLE_BYTE;
        end
        return d;
    endfunction

    eth_tx_state_e           r_state;
    logic [BEAT_W-1:0]       r_beat;
    logic [IFG_W-1:0]        r_ifg;
    logic [15:0]             r_frame_count;
    logic [8*DATA_BYTES-1:0] r_tdata;
    logic [DATA_BYTES-1:0]   r_tkeep;
    logic                    r_tvalid;

    logic                    w_in_payload;
    logic                    w_last_hs;

    assign w_in_payload = (r_state == ST_PAYLOAD);
    assign w_last_hs    = s_axis_tvalid && m_axis_tready && s_axis_tlast;

    // Framer FSM: sequences preamble beats, tracks the payload, times the gap.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_beat        <= '0;
            r_ifg         <= '0;
            r_frame_count <= '0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tvalid      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        r_state  <= ST_PREAMBLE;
                        r_beat   <= '0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= preamble_beat('0);
                        r_tkeep  <= '1;
                    end
                end
                ST_PREAMBLE: begin
                    // r_tvalid is always high here, so ready alone marks the handshake.
                    if (m_axis_tready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state  <= ST_PAYLOAD;
                            r_beat   <= '0;
                            r_tvalid <= 1'b0;
                            r_tdata  <= '0;
                            r_tkeep  <= '0;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_tdata <= preamble_beat(r_beat + 1'b1);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_last_hs) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        if (IFG_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_IFG;
                            r_ifg   <= '0;
                        end
                    end
                end
                ST_IFG: begin
                    if (r_ifg == LAST_IFG) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg <= r_ifg + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: payload is a pure continuous-assign mux; nothing is held, so no latch can form.
    assign m_axis_tdata  = w_in_payload ? s_axis_tdata  : r_tdata;
    assign m_axis_tkeep  = w_in_payload ? s_axis_tkeep  : r_tkeep;
    assign m_axis_tvalid = w_in_payload ? s_axis_tvalid : r_tvalid;
    assign m_axis_tlast  = w_in_payload & s_axis_tlast;
    assign m_axis_tuser  = w_in_payload & s_axis_tuser;
    assign s_axis_tready = w_in_payload & m_axis_tready;

    assign busy        = (r_state != ST_IDLE);
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_preamble_sfd_inserter.sv
// Directed self-checking bench: three instances cover 1-, 4- and 8-byte beats.
module tb_preamble_sfd_inserter;

    logic aclk;
    logic aresetn;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DATA_BYTES = 1 instance ----------------
    logic [7:0]  s1_tdata;
    logic [0:0]  s1_tkeep;
    logic        s1_tvalid, s1_tlast, s1_tuser, s1_tready;
    logic [7:0]  m1_tdata;
    logic [0:0]  m1_tkeep;
    logic        m1_tvalid, m1_tlast, m1_tuser, m1_tready;
    logic        busy1;
    logic [15:0] fc1;

    preamble_sfd_inserter #(.DATA_BYTES(1), .PREAMBLE_LEN(8), .IFG_BYTES(12)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tvalid(s1_tvalid),
        .s_axis_tlast(s1_tlast), .s_axis_tuser(s1_tuser), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
        .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser), .m_axis_tready(m1_tready),
        .busy(busy1), .frame_count(fc1)
    );

    // ---------------- DATA_BYTES = 4 instance ----------------
    logic [31:0] s4_tdata;
    logic [3:0]  s4_tkeep;
    logic        s4_tvalid, s4_tlast, s4_tuser, s4_tready;
    logic [31:0] m4_tdata;
    logic [3:0]  m4_tkeep;
    logic        m4_tvalid, m4_tlast, m4_tuser;
    logic        m4_tready = 1'b1;
    logic        busy4;
    logic [15:0] fc4;

    preamble_sfd_inserter #(.DATA_BYTES(4), .PREAMBLE_LEN(8), .IFG_BYTES(12)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s4_tdata), .s_axis_tkeep(s4_tkeep), .s_axis_tvalid(s4_tvalid),
        .s_axis_tlast(s4_tlast), .s_axis_tuser(s4_tuser), .s_axis_tready(s4_tready),
        .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep), .m_axis_tvalid(m4_tvalid),
        .m_axis_tlast(m4_tlast), .m_axis_tuser(m4_tuser), .m_axis_tready(m4_tready),
        .busy(busy4), .frame_count(fc4)
    );

    // ---------------- DATA_BYTES = 8 instance ----------------
    logic [63:0] s8_tdata;
    logic [7:0]  s8_tkeep;
    logic        s8_tvalid, s8_tlast, s8_tuser, s8_tready;
    logic [63:0] m8_tdata;
    logic [7:0]  m8_tkeep;
    logic        m8_tvalid, m8_tlast, m8_tuser;
    logic        m8_tready = 1'b1;
    logic        busy8;
    logic [15:0] fc8;

    preamble_sfd_inserter #(.DATA_BYTES(8), .PREAMBLE_LEN(8), .IFG_BYTES(12)) u_dut8 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s8_tdata), .s_axis_tkeep(s8_tkeep), .s_axis_tvalid(s8_tvalid),
        .s_axis_tlast(s8_tlast), .s_axis_tuser(s8_tuser), .s_axis_tready(s8_tready),
        .m_axis_tdata(m8_tdata), .m_axis_tkeep(m8_tkeep), .m_axis_tvalid(m8_tvalid),
        .m_axis_tlast(m8_tlast), .m_axis_tuser(m8_tuser), .m_axis_tready(m8_tready),
        .busy(busy8), .frame_count(fc8)
    );

    // ---------------- DB1 output monitor ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       s_rdy;
        int         cyc;
    } beat_t;

    beat_t       q[$];
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record accepted output beats; a stalled beat must reappear unchanged.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m1_tvalid, 1'b1);
                check("hold_data", m1_tdata, prev_data);
            end
            if (m1_tvalid && m1_tready)
                q.push_back('{data: m1_tdata, last: m1_tlast, s_rdy: s1_tready, cyc: cyc});
            prev_stall = m1_tvalid && !m1_tready;
            prev_data  = m1_tdata;
        end
    end

    // ---------------- DB1 output ready pattern ----------------
    logic        stall_mode = 1'b0;
    logic [15:0] stall_pat  = 16'b0110_0101_1001_1010;
    int          stall_idx  = 0;

    initial begin
        m1_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (stall_mode) begin
                m1_tready = stall_pat[stall_idx];
                stall_idx = (stall_idx + 1) % 16;
            end else begin
                m1_tready = 1'b1;
            end
        end
    end

    // Present one byte and hold it until the DUT accepts it (bounded wait).
    task automatic send_beat1(input logic [7:0] data, input logic last);
        bit done = 0;
        int n    = 0;
        s1_tvalid = 1'b1;
        s1_tdata  = data;
        s1_tkeep  = 1'b1;
        s1_tlast  = last;
        s1_tuser  = 1'b0;
        while (!done && n < 200) begin
            @(negedge aclk);
            done = s1_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        check("src_handshake", done, 1'b1);
    endtask

    // Send n bytes base, base+1, ...; optional two-cycle source bubble after byte bubble_after.
    task automatic send_frame1(input int n, input logic [7:0] base, input int bubble_after);
        for (int i = 0; i < n; i++) begin
            send_beat1(base + 8'(i), i == n - 1);
            if (i == bubble_after && i != n - 1) begin
                s1_tvalid = 1'b0;
                repeat (2) begin
                    @(negedge aclk);
                    check("bubble_valid", m1_tvalid, 1'b0);
                    check("bubble_busy", busy1, 1'b1);
                    @(posedge aclk);
                    #1;
                end
            end
        end
    endtask

    // Compare captured beats from index first against 55x7, D5, then the payload bytes.
    task automatic check_frame1(input string tag, input int first, input int n, input logic [7:0] base);
        logic ok;
        ok = (q.size() >= first + 8 + n);
        check({tag, "_size"}, ok, 1'b1);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                check({tag, "_pre_data"}, q[first+i].data, (i == 7) ? 8'hD5 : 8'h55);
                check({tag, "_pre_last"}, q[first+i].last, 1'b0);
                check({tag, "_pre_s_rdy"}, q[first+i].s_rdy, 1'b0);
            end
            for (int i = 0; i < n; i++) begin
                check({tag, "_pay_data"}, q[first+8+i].data, base + 8'(i));
                check({tag, "_pay_last"}, q[first+8+i].last, i == n - 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        int nlast;
        aresetn   = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        s4_tvalid = 1'b0; s4_tdata = '0; s4_tkeep = '0; s4_tlast = 1'b0; s4_tuser = 1'b0;
        s8_tvalid = 1'b0; s8_tdata = '0; s8_tkeep = '0; s8_tlast = 1'b0; s8_tuser = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_valid", m1_tvalid, 1'b0);
        check("rst_m_data", m1_tdata, 8'h00);
        check("rst_m_keep", m1_tkeep, 1'b0);
        check("rst_s_ready", s1_tready, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_fc", fc1, 16'd0);
        check("rst_m4_valid", m4_tvalid, 1'b0);
        check("rst_m8_data", m8_tdata, 64'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // ---- DATA_BYTES=4, 8-byte frame ----
        @(posedge aclk); #1;
        s4_tvalid = 1'b1; s4_tdata = 32'h4433_2211; s4_tkeep = 4'hF; s4_tlast = 1'b0;
        @(negedge aclk);
        check("db4_idle_s_ready", s4_tready, 1'b0);
        check("db4_idle_m_valid", m4_tvalid, 1'b0);
        @(posedge aclk); #1; @(negedge aclk);
        check("db4_pre0_data", m4_tdata, 32'h5555_5555);
        check("db4_pre0_valid", m4_tvalid, 1'b1);
        check("db4_pre0_keep", m4_tkeep, 4'hF);
        check("db4_pre0_s_ready", s4_tready, 1'b0);
        @(posedge aclk); #1; @(negedge aclk);
        check("db4_pre1_data", m4_tdata, 32'hD555_5555);
        check("db4_pre1_last", m4_tlast, 1'b0);
        @(posedge aclk); #1; @(negedge aclk);
        check("db4_pay0_data", m4_tdata, 32'h4433_2211);
        check("db4_pay0_keep", m4_tkeep, 4'hF);
        check("db4_pay0_s_ready", s4_tready, 1'b1);
        check("db4_pay0_last", m4_tlast, 1'b0);
        @(posedge aclk); #1;
        s4_tdata = 32'h8877_6655; s4_tlast = 1'b1;
        @(negedge aclk);
        check("db4_pay1_data", m4_tdata, 32'h8877_6655);
        check("db4_pay1_last", m4_tlast, 1'b1);
        @(posedge aclk); #1;
        s4_tvalid = 1'b0; s4_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("db4_ifg_busy", busy4, 1'b1);
            check("db4_ifg_valid", m4_tvalid, 1'b0);
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("db4_after_ifg_busy", busy4, 1'b0);
        check("db4_fc", fc4, 16'd1);

        // ---- DATA_BYTES=8, single-beat frame, partial keep, tuser set ----
        @(posedge aclk); #1;
        s8_tvalid = 1'b1; s8_tdata = 64'h0000_0000_00CC_BBAA; s8_tkeep = 8'h07;
        s8_tlast = 1'b1; s8_tuser = 1'b1;
        @(negedge aclk);
        check("db8_idle_m_valid", m8_tvalid, 1'b0);
        @(posedge aclk); #1; @(negedge aclk);
        check("db8_pre_data", m8_tdata, 64'hD555_5555_5555_5555);
        check("db8_pre_keep", m8_tkeep, 8'hFF);
        check("db8_pre_user", m8_tuser, 1'b0);
        check("db8_pre_s_ready", s8_tready, 1'b0);
        @(posedge aclk); #1; @(negedge aclk);
        check("db8_pay_data", m8_tdata, 64'h0000_0000_00CC_BBAA);
        check("db8_pay_keep", m8_tkeep, 8'h07);
        check("db8_pay_user", m8_tuser, 1'b1);
        check("db8_pay_last", m8_tlast, 1'b1);
        check("db8_pay_valid", m8_tvalid, 1'b1);
        @(posedge aclk); #1;
        s8_tvalid = 1'b0; s8_tlast = 1'b0; s8_tuser = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("db8_ifg_busy", busy8, 1'b1);
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("db8_after_ifg_busy", busy8, 1'b0);
        check("db8_fc", fc8, 16'd1);

        // ---- DATA_BYTES=1, 4-byte frame, then 12 idle cycles ----
        @(posedge aclk); #1;
        q.delete();
        send_frame1(4, 8'hA1, -1);
        s1_tvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            check("t1_ifg_busy", busy1, 1'b1);
            check("t1_ifg_valid", m1_tvalid, 1'b0);
            check("t1_ifg_s_ready", s1_tready, 1'b0);
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("t1_after_ifg_busy", busy1, 1'b0);
        check("t1_beats", q.size(), 12);
        check_frame1("t1", 0, 4, 8'hA1);
        check("t1_fc", fc1, 16'd1);

        // ---- back-to-back frames with a mid-payload bubble ----
        @(posedge aclk); #1;
        q.delete();
        send_frame1(3, 8'hB0, 0);
        send_frame1(2, 8'hC0, -1);
        s1_tvalid = 1'b0;
        repeat (16) @(posedge aclk);
        #1;
        check("b2b_beats", q.size(), 21);
        check_frame1("b2b_f1", 0, 3, 8'hB0);
        check_frame1("b2b_f2", 11, 2, 8'hC0);
        gap = (q.size() >= 12) ? (q[11].cyc - q[10].cyc - 1) : 0;
        check("b2b_gap_ge12", gap >= 12, 1'b1);
        check("b2b_fc", fc1, 16'd3);

        // ---- output back-pressure through the preamble ----
        q.delete();
        stall_mode = 1'b1;
        send_frame1(2, 8'hD0, -1);
        s1_tvalid  = 1'b0;
        stall_mode = 1'b0;
        repeat (16) @(posedge aclk);
        #1;
        check("stall_beats", q.size(), 10);
        check_frame1("stall", 0, 2, 8'hD0);
        check("stall_fc", fc1, 16'd4);

        // ---- reset pulse in the middle of a payload ----
        q.delete();
        send_beat1(8'hE0, 1'b0);
        send_beat1(8'hE1, 1'b0);
        s1_tvalid = 1'b0;
        aresetn   = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("midrst_m_valid", m1_tvalid, 1'b0);
        check("midrst_m_data", m1_tdata, 8'h00);
        check("midrst_m_keep", m1_tkeep, 1'b0);
        check("midrst_m_last", m1_tlast, 1'b0);
        check("midrst_m_user", m1_tuser, 1'b0);
        check("midrst_s_ready", s1_tready, 1'b0);
        check("midrst_busy", busy1, 1'b0);
        check("midrst_fc", fc1, 16'd0);
        nlast = 0;
        foreach (q[i]) if (q[i].last) nlast++;
        check("midrst_no_tlast", nlast, 0);
        check("midrst_beats_before", q.size(), 10);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        q.delete();
        send_frame1(3, 8'hF0, -1);
        s1_tvalid = 1'b0;
        repeat (16) @(posedge aclk);
        #1;
        check_frame1("post_rst", 0, 3, 8'hF0);
        check("post_rst_fc", fc1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/preamble_sfd_inserter.md
PREAMBLE_SFD_INSERTER -- requirements
Module: preamble_sfd_inserter

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 1, bytes per beat; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have parameter PREAMBLE_LEN, default 8, bytes of preamble plus SFD; a multiple of DATA_BYTES, at least DATA_BYTES.
REQ-003 The block SHALL have parameter IFG_BYTES, default 12, minimum idle bytes between frames; 0 is legal.
REQ-004 The block SHALL have the ports aclk in 1 (clock) and aresetn in 1 (reset, synchronous, active-low); all logic is on aclk rising edge.
REQ-005 The block SHALL have the AXI-Stream payload input ports s_axis_tdata in 8*DATA_BYTES, s_axis_tkeep in DATA_BYTES, s_axis_tvalid in 1, s_axis_tlast in 1 and s_axis_tuser in 1 (error flag), plus s_axis_tready out 1.
REQ-006 The block SHALL have the output ports m_axis_tdata out 8*DATA_BYTES, m_axis_tkeep out DATA_BYTES, m_axis_tvalid out 1, m_axis_tlast out 1 and m_axis_tuser out 1, plus m_axis_tready in 1.
REQ-007 The block SHALL have the status ports busy out 1 (state not IDLE) and frame_count out 16 (completed frames, wrapping).

Function
REQ-008 Byte lane 0 SHALL be the first transmitted byte.
REQ-009 The FSM SHALL have the states IDLE, PREAMBLE, PAYLOAD and IFG.
REQ-010 IDLE: s_axis_tready=0 and m_axis_tvalid=0; s_axis_tvalid=1 SHALL move the FSM to PREAMBLE next cycle with the beat counter at 0.
REQ-011 PREAMBLE SHALL emit NB=PREAMBLE_LEN/DATA_BYTES beats from registers: every byte 0x55, except lane DATA_BYTES-1 of beat NB-1, which is 0xD5.
REQ-012 Preamble beats SHALL have m_axis_tkeep all ones, m_axis_tlast=0 and m_axis_tuser=0.
REQ-013 In PREAMBLE, m_axis_tvalid SHALL be 1 and each beat SHALL be held stable until m_axis_tready=1.
REQ-014 The counter SHALL advance only on an m_axis handshake; the handshake on beat NB-1 SHALL move the FSM to PAYLOAD.
REQ-015 In PREAMBLE, s_axis_tready SHALL be 0, so no payload is consumed.
REQ-016 PAYLOAD SHALL be a combinational pass-through: m_axis_tdata/tkeep/tlast/tuser/tvalid = s_axis_*, and s_axis_tready = m_axis_tready, with zero added latency.
REQ-017 A handshake with s_axis_tlast=1 SHALL increment frame_count (mod 2^16) and move the FSM to IFG, or to IDLE when IFG_BYTES=0.
REQ-018 s_axis_tkeep SHALL be contiguous from lane 0; partial keep is legal only on the tlast beat; the block forwards tkeep and does not check it.
REQ-019 IFG SHALL hold for ceil(IFG_BYTES/DATA_BYTES) cycles with s_axis_tready=0 and m_axis_tvalid=0, then go to IDLE.
REQ-020 A frame pending during IFG SHALL start PREAMBLE no earlier than the cycle after leaving IFG, via IDLE.
REQ-021 A tlast beat whose tuser=1 SHALL be forwarded unmodified; the block does not drop or truncate frames.
REQ-022 s_axis_tvalid deasserting mid-payload SHALL produce m_axis_tvalid=0 bubbles, with the FSM staying in PAYLOAD.
REQ-023 A frame of a single beat with tlast=1 SHALL be legal: preamble, then one payload beat, then IFG.

Reset
REQ-024 With aresetn=0 at a clock edge, the FSM SHALL go to IDLE and the beat and IFG counters SHALL clear to 0.
REQ-025 With aresetn=0 at a clock edge, frame_count SHALL clear to 0.
REQ-026 With aresetn=0 at a clock edge, registered outputs SHALL be m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0 and busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no tlast emitted; the next frame after reset SHALL begin with a full preamble.

Structure
REQ-028 The constants PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5 and the FSM state enum SHALL live in the shared Ethernet package, eth_pkg.
REQ-029 Parameter legality (DATA_BYTES value, PREAMBLE_LEN divisibility) SHALL be checked at elaboration.
REQ-030 The design SHALL be a single module with no sub-modules; the counters are sized by $clog2 of their limits.

Verification
REQ-031 DATA_BYTES=1, 4-byte frame, m_axis_tready=1 -> out 55x7, D5, 4 payload bytes (last with tlast), 12 idle cycles; frame_count=1.
REQ-032 DATA_BYTES=4, 8-byte frame -> beats 0x55555555, 0xD5555555, 2 payload beats with tkeep=F; 3 IFG cycles.
REQ-033 DATA_BYTES=8, last beat tkeep=0x07, tuser=1 -> one preamble beat 0xD555555555555555; last beat forwarded with tkeep=0x07, tuser=1, tlast=1.
REQ-034 m_axis_tready toggled 1-0-1 through preamble -> each beat held stable while stalled; exactly NB beats; no s_axis handshake before the SFD beat is accepted.
REQ-035 Two back-to-back frames with IFG_BYTES=12, DATA_BYTES=1 -> at least 12 cycles with m_axis_tvalid=0 between the first tlast and the second 0x55.
REQ-036 aresetn=0 pulsed during payload -> all outputs at reset values next cycle; the following frame begins with a full preamble; frame_count=0.
